// File: rtl/dtree_stream_loader_pkg.sv
// Shared types and sizes for the decision-tree stream loader.
package dtree_pkg;

  localparam int NUM_FEATURES = 9;
  localparam int FEAT_W       = 8;
  localparam int CLASS_W      = 2;
  localparam int CNT_W        = 16;
  localparam int IDX_W        = $clog2(NUM_FEATURES);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/dtree_stream_loader_if.sv
// Feature byte stream in and class result stream out of the loader.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready; the source holds valid and its payload stable until
// that edge, and ready may be asserted independently of valid.
interface dtree_stream_loader_if
  import dtree_pkg::*;
#(
  parameter int DATA_W = FEAT_W,
  parameter int CLS_W  = CLASS_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              m_valid;
  logic              m_ready;
  logic [CLS_W-1:0]  m_class;
  logic              m_error;

  // master: upstream byte source and downstream result sink
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_error
  );

  // slave: the loader itself
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_error
  );

endinterface

// File: rtl/dtree_stream_loader.sv
// Assembles a byte stream into the parallel feature bus for an external
// combinational decision tree and returns the registered class as a result.
module dtree_stream_loader
  import dtree_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  dtree_stream_loader_if.slave           bus,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           drop_pulse,
  output logic [CNT_W-1:0]               vec_cnt,
  output state_t                         state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [FEAT_W-1:0]    feat [NUM_FEATURES];
  logic                 err_r;
  logic                 m_valid_q;
  logic [CLASS_W-1:0]   m_class_q;
  logic                 m_error_q;
  logic                 drop_q;
  logic [CNT_W-1:0]     vec_cnt_q;
  logic                 accept;
  logic                 deliver;

  assign bus.s_ready = (state == LOAD);
  assign accept      = bus.s_valid && (state == LOAD);
  assign deliver     = (state == HOLD) && m_valid_q && bus.m_ready;

  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign bus.m_error = m_error_q;
  assign drop_pulse  = drop_q;
  assign vec_cnt     = vec_cnt_q;
  assign state_dbg   = state;

  always_comb begin
    feat_bus = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      feat_bus[k*FEAT_W +: FEAT_W] = feat[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && (idx == LAST_IDX)) state_nxt = EVAL;
      EVAL:    state_nxt = HOLD;
      HOLD:    if (deliver) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      err_r     <= 1'b0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      m_error_q <= 1'b0;
      drop_q    <= 1'b0;
      vec_cnt_q <= '0;
      for (int k = 0; k < NUM_FEATURES; k++) begin
        feat[k] <= '0;
      end
    end else begin
      drop_q <= 1'b0;

      if (accept) begin
        feat[idx] <= bus.s_data;
        if (idx == LAST_IDX) begin
          // A missing last marker is flagged but the vector is still evaluated.
          idx   <= '0;
          err_r <= ~bus.s_last;
        end else if (bus.s_last) begin
          // Short vector: discard it, leaving the partial bytes on feat_bus.
          idx    <= '0;
          drop_q <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      if (state == EVAL) begin
        m_class_q <= tree_class;
        m_error_q <= err_r;
        m_valid_q <= 1'b1;
      end

      if (deliver) begin
        m_valid_q <= 1'b0;
        vec_cnt_q <= vec_cnt_q + 1'b1;
      end
    end
  end

endmodule
